// File: rtl/locker_pkg.sv
// locker_pkg: shared button count, key codes and arbiter state encoding for the locker
package locker_pkg;
    localparam int BTN_COUNT = 6;
    localparam logic [2:0] KEY_A = 3'd0;
    localparam logic [2:0] KEY_B = 3'd1;
    localparam logic [2:0] KEY_C = 3'd2;
    localparam logic [2:0] KEY_D = 3'd3;
    localparam logic [2:0] KEY_E = 3'd4;
    localparam logic [2:0] KEY_F = 3'd5;
    typedef enum logic [1:0] {WAIT_REL, IDLE, HELD} arb_state_t;
    // Index of the lowest set bit; the arbiter only uses it on one-hot vectors.
    function automatic logic [2:0] first_set(input logic [BTN_COUNT-1:0] v);
        first_set = '0;
        for (int i = BTN_COUNT - 1; i >= 0; i--)
            if (v[i]) first_set = 3'(i);
    endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer plus shared-counter debouncer for a button vector
//   clk_i, rst_ni (async active-low), btn_i[W] raw buttons
//   stable_o[W] accepted vector, primed_o set once the first vector has been accepted
module btn_debounce #(
    parameter int W = 6,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] btn_i,
    output logic [W-1:0] stable_o,
    output logic         primed_o
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic [W-1:0] sync1_q, sync2_q, last_q, last_d, stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic primed_q, primed_d;
    // One counter serves the whole vector: any change on any bit restarts it.
    always_comb begin
        last_d = last_q;
        cnt_d = cnt_q;
        stable_d = stable_q;
        primed_d = primed_q;
        if (sync2_q != last_q) begin
            last_d = sync2_q;
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            stable_d = last_q;
            primed_d = 1'b1;
        end
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
            last_q <= '0;
            cnt_q <= '0;
            stable_q <= '0;
            primed_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            last_q <= last_d;
            cnt_q <= cnt_d;
            stable_q <= stable_d;
            primed_q <= primed_d;
        end
    end
    assign stable_o = stable_q;
    assign primed_o = primed_q;
endmodule

// File: rtl/key_arbiter.sv
// key_arbiter: debounces the locker buttons and issues one key event per press-release cycle
//   clk_i, rst_ni (async active-low), btn_i[6] raw buttons A..F, en_i key acceptance enable
//   key_valid_o single-key pulse with key_code_o, key_err_o multi-key pulse, busy_o not idle
module key_arbiter
    import locker_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [BTN_COUNT-1:0] btn_i,
    input  logic                 en_i,
    output logic                 key_valid_o,
    output logic [2:0]           key_code_o,
    output logic                 key_err_o,
    output logic                 busy_o
);
    logic [BTN_COUNT-1:0] stable;
    logic primed;
    arb_state_t state_q;
    logic key_valid_q, key_err_q, busy_q;
    logic [2:0] key_code_q;
    btn_debounce #(.W(BTN_COUNT), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .btn_i   (btn_i),
        .stable_o(stable),
        .primed_o(primed)
    );
    // An event is decided only on IDLE->HELD; everything seen while HELD except
    // an all-released vector is ignored, so one press cycle yields one event.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= WAIT_REL;
            key_valid_q <= 1'b0;
            key_err_q <= 1'b0;
            key_code_q <= '0;
            busy_q <= 1'b1;
        end else begin
            key_valid_q <= 1'b0;
            key_err_q <= 1'b0;
            key_code_q <= '0;
            case (state_q)
                WAIT_REL: if (primed && stable == '0) begin
                    state_q <= IDLE;
                    busy_q <= 1'b0;
                end
                IDLE: if (stable != '0) begin
                    state_q <= HELD;
                    busy_q <= 1'b1;
                    if (en_i) begin
                        key_valid_q <= $onehot(stable);
                        key_err_q <= !$onehot(stable);
                        key_code_q <= $onehot(stable) ? first_set(stable) : 3'd0;
                    end
                end
                HELD: if (stable == '0) begin
                    state_q <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state_q <= WAIT_REL;
                    busy_q <= 1'b1;
                end
            endcase
        end
    end
    assign key_valid_o = key_valid_q;
    assign key_err_o = key_err_q;
    assign key_code_o = key_code_q;
    assign busy_o = busy_q;
endmodule

// File: tb/tb_key_arbiter.sv
// tb_key_arbiter: directed and random stimulus against a history-window reference model
module tb_key_arbiter;
    import locker_pkg::*;
    localparam int D = 4;
    logic clk = 1'b0;
    logic rst_ni = 1'b1;
    logic en_i = 1'b1;
    logic [5:0] btn_i = '0;
    logic key_valid_o, key_err_o, busy_o;
    logic [2:0] key_code_o;
    key_arbiter #(.DEBOUNCE_CYCLES(D)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .btn_i      (btn_i),
        .en_i       (en_i),
        .key_valid_o(key_valid_o),
        .key_code_o (key_code_o),
        .key_err_o  (key_err_o),
        .busy_o     (busy_o)
    );
    always #5 clk = ~clk;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    // Model: h holds every BTN sample since reset (-1 = before reset history);
    // a vector is accepted once the samples two to D+2 edges back all agree.
    int h[$];
    logic [5:0] m_stable;
    bit m_primed;
    bit m_waiting, m_held;
    logic exp_v, exp_e, exp_b;
    logic [2:0] exp_c;
    int n_v, n_e, v_cyc, fall_cyc, p, r;
    logic [2:0] v_code;
    logic busy_prev;
    logic [5:0] rv;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic model_reset();
        h.delete();
        repeat (D) h.push_back(-1);
        repeat (3) h.push_back(0);
        m_stable = '0;
        m_primed = 0;
        m_waiting = 1;
        m_held = 0;
        exp_v = 0;
        exp_e = 0;
        exp_c = '0;
        exp_b = 1;
    endtask
    task automatic model_edge(input logic [5:0] b, input logic en);
        int ref_v;
        bit ok;
        h.push_back(int'(b));
        exp_v = 0;
        exp_e = 0;
        exp_c = '0;
        if (m_waiting) begin
            if (m_primed && m_stable == 0) m_waiting = 0;
        end else if (!m_held) begin
            if (m_stable != 0) begin
                m_held = 1;
                if (en) begin
                    if ($countones(m_stable) == 1) begin
                        exp_v = 1;
                        for (int i = 0; i < 6; i++) if (m_stable[i]) exp_c = 3'(i);
                    end else exp_e = 1;
                end
            end
        end else if (m_stable == 0) m_held = 0;
        exp_b = m_waiting || m_held;
        ref_v = h[h.size() - 3];
        ok = ref_v >= 0;
        for (int k = 2; k <= D + 2; k++) if (h[h.size() - 1 - k] != ref_v) ok = 0;
        if (ok) begin
            m_stable = 6'(ref_v);
            m_primed = 1;
        end
        if (h.size() > 64) void'(h.pop_front());
    endtask
    task automatic tick(input logic [5:0] b);
        btn_i = b;
        @(posedge clk);
        model_edge(b, en_i);
        cyc++;
        @(negedge clk);
        chk("key_valid", key_valid_o, exp_v);
        chk("key_err", key_err_o, exp_e);
        chk("key_code", key_code_o, exp_c);
        chk("busy", busy_o, exp_b);
        if (key_valid_o) begin
            n_v++;
            v_cyc = cyc;
            v_code = key_code_o;
        end
        if (key_err_o) n_e++;
        if (busy_prev && !busy_o) fall_cyc = cyc;
        busy_prev = busy_o;
    endtask
    task automatic hold(input logic [5:0] b, input int n);
        repeat (n) tick(b);
    endtask
    task automatic do_reset(input logic [5:0] b);
        btn_i = b;
        #2 rst_ni = 1'b0;
        #1;
        chk("rst_valid", key_valid_o, 0);
        chk("rst_err", key_err_o, 0);
        chk("rst_code", key_code_o, 0);
        chk("rst_busy", busy_o, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        model_reset();
        busy_prev = 1'b1;
    endtask
    initial begin
        @(negedge clk);
        do_reset('0);
        hold('0, 10);
        chk("idle_busy", busy_o, 0);
        // clean press of C
        n_v = 0;
        n_e = 0;
        p = cyc + 1;
        hold(6'b000100, 20);
        chk("c_count", n_v, 1);
        chk("c_latency", v_cyc - p, 7);
        chk("c_code", v_code, KEY_C);
        r = cyc + 1;
        hold('0, 12);
        chk("c_busy_drop", fall_cyc - r, 7);
        // bounce: 2-cycle pulses never accepted, count starts at the final toggle
        n_v = 0;
        repeat (2) begin
            hold(6'b000001, 2);
            hold('0, 2);
        end
        p = cyc + 1;
        hold(6'b000001, 14);
        chk("bounce_count", n_v, 1);
        chk("bounce_latency", v_cyc - p, 7);
        hold('0, 12);
        // A and D together, then D released while A held
        n_v = 0;
        n_e = 0;
        hold(6'b001001, 10);
        chk("ad_err", n_e, 1);
        hold(6'b000001, 12);
        hold('0, 12);
        chk("ad_err_total", n_e, 1);
        chk("ad_valid", n_v, 0);
        // EN low masks the event but still tracks the hold
        en_i = 1'b0;
        n_v = 0;
        n_e = 0;
        hold(6'b100000, 10);
        chk("f_busy_held", busy_o, 1);
        hold('0, 12);
        chk("f_masked", n_v + n_e, 0);
        en_i = 1'b1;
        hold(6'b100000, 12);
        chk("f_count", n_v, 1);
        chk("f_code", v_code, KEY_F);
        hold('0, 12);
        // B held through reset release
        do_reset(6'b000010);
        n_v = 0;
        n_e = 0;
        hold(6'b000010, 15);
        chk("b_held_busy", busy_o, 1);
        chk("b_held_none", n_v + n_e, 0);
        hold('0, 12);
        chk("b_rel_busy", busy_o, 0);
        hold(6'b000010, 12);
        chk("b_count", n_v, 1);
        chk("b_code", v_code, KEY_B);
        do_reset(6'b000010);
        hold('0, 12);
        // random presses with random enable
        repeat (60) begin
            case ($urandom_range(0, 2))
                0: rv = '0;
                1: rv = 6'(1 << $urandom_range(0, BTN_COUNT - 1));
                default: rv = 6'($urandom_range(0, 63));
            endcase
            en_i = $urandom_range(0, 3) != 0;
            hold(rv, int'($urandom_range(1, 12)));
        end
        hold('0, 12);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
